// File: rtl/uart_tx_core.sv
// uart_tx_core: valid/ready byte-in UART transmitter with integrated baud divider and optional parity
module uart_tx_core #(
  parameter int BAUD_DIV = 217,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic stp_q, stp_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d;
  logic tx_q, tx_d;
  logic rdy_q, rdy_d;
  logic busy_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    stp_d = stp_q;
    sh_d = sh_q;
    par_d = par_q;
    tx_d = tx_q;
    rdy_d = rdy_q;
    if (state_q == IDLE) begin
      if (valid_i && rdy_q) begin
        state_d = START;
        cnt_d = RELOAD;
        sh_d = data_i;
        par_d = ^data_i ^ (PARITY == 2);
        tx_d = 1'b0;
        rdy_d = 1'b0;
      end
    end else begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
      if (cnt_q == '0) begin
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d = 3'd0;
            tx_d = sh_q[0];
          end
          DATA: begin
            if (bit_q == 3'd7) begin
              state_d = (PARITY != 0) ? PAR : STOP;
              stp_d = 1'b0;
              tx_d = (PARITY != 0) ? par_q : 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d = {1'b0, sh_q[7:1]};
              tx_d = sh_q[1];
            end
          end
          PAR: begin
            state_d = STOP;
            stp_d = 1'b0;
            tx_d = 1'b1;
          end
          STOP: begin
            state_d = (stp_q == STOP_LAST) ? IDLE : STOP;
            rdy_d = (stp_q == STOP_LAST);
            stp_d = 1'b1;
            tx_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= 3'd0;
      stp_q <= 1'b0;
      sh_q <= 8'd0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      rdy_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      stp_q <= stp_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
      rdy_q <= rdy_d;
      busy_q <= ~rdy_d;
    end
  end
  assign ready_o = rdy_q;
  assign busy_o = busy_q;
  assign tx_o = tx_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: four parameterisations checked against hand tables and a frame-level reference model
module tb_uart_tx_core;
  localparam int BD = 4;
  localparam int PAR [4] = '{0, 1, 2, 0};
  localparam int STP [4] = '{1, 1, 1, 2};
  typedef struct {
    int i;
    logic [7:0] d;
    logic [15:0] bits;
    int len;
    string name;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data [4];
  logic valid [4];
  logic ready [4];
  logic tx [4];
  logic busy [4];
  int pass = 0;
  int total = 0;
  logic wave [$];
  int flen;
  logic hist [$];
  bit rec = 1'b0;
  vec_t vecs [5];
  always #5 clk = ~clk;
  always @(negedge clk) if (rec) hist.push_back(tx[3]);
  uart_tx_core #(.BAUD_DIV(BD), .PARITY(0), .STOP_BITS(1)) u0 (.clk_i(clk), .rst_i(rst), .data_i(data[0]), .valid_i(valid[0]), .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));
  uart_tx_core #(.BAUD_DIV(BD), .PARITY(1), .STOP_BITS(1)) u1 (.clk_i(clk), .rst_i(rst), .data_i(data[1]), .valid_i(valid[1]), .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));
  uart_tx_core #(.BAUD_DIV(BD), .PARITY(2), .STOP_BITS(1)) u2 (.clk_i(clk), .rst_i(rst), .data_i(data[2]), .valid_i(valid[2]), .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));
  uart_tx_core #(.BAUD_DIV(BD), .PARITY(0), .STOP_BITS(2)) u3 (.clk_i(clk), .rst_i(rst), .data_i(data[3]), .valid_i(valid[3]), .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]));
  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    total++;
    if (ok) pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask
  function automatic int nbits(input int i);
    return 9 + ((PAR[i] != 0) ? 1 : 0) + STP[i];
  endfunction
  // Line level during frame bit b: start, 8 data LSB first, optional parity, then stop bits.
  function automatic logic mbit(input int i, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && PAR[i] != 0) return (^d) ^ (PAR[i] == 2);
    return 1'b1;
  endfunction
  // Starts on a falling edge; returns on the falling edge after ready reasserts (or on timeout).
  task automatic run_frame(input int i, input logic [7:0] d, input bit hold, input logic [7:0] nxt, input bit abuse);
    int n;
    bit cmp;
    n = nbits(i) * BD;
    cmp = 1'b1;
    wave = {};
    flen = -1;
    data[i] = d;
    valid[i] = 1'b1;
    for (int k = 0; k < 50 && ready[i] !== 1'b1; k++) @(negedge clk);
    check($sformatf("ready_before_accept_%0d", i), ready[i] === 1'b1, longint'(ready[i]), 1);
    @(posedge clk);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) begin
        valid[i] = hold;
        if (hold) data[i] = nxt;
      end else if (abuse) begin
        valid[i] = (c < n - 1) ? 1'($urandom) : 1'b0;
        data[i] = 8'($urandom);
      end
      if (busy[i] === ready[i]) cmp = 1'b0;
      if (ready[i] === 1'b1) begin
        flen = c;
        break;
      end
      wave.push_back(tx[i]);
    end
    check($sformatf("frame_done_%0d", i), flen >= 0, flen, n);
    check($sformatf("busy_complement_%0d", i), cmp, cmp, 1);
    check($sformatf("tx_idle_after_%0d", i), tx[i] === 1'b1 && busy[i] === 1'b0, longint'(tx[i]), 1);
  endtask
  task automatic check_model(input int i, input logic [7:0] d, input string nm);
    int n;
    int bad;
    n = nbits(i) * BD;
    bad = -1;
    for (int c = 0; c < n; c++)
      if (bad < 0 && (c >= wave.size() || wave[c] !== mbit(i, d, c / BD))) bad = c;
    check({nm, "_len"}, flen == n, flen, n);
    check({nm, "_wave_first_bad_cycle"}, bad < 0, bad, -1);
  endtask
  task automatic idle_watch(input int i, input int n, input string nm);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (tx[i] !== 1'b1 || ready[i] !== 1'b1 || busy[i] !== 1'b0) ok = 1'b0;
    end
    check(nm, ok, ok, 1);
  endtask
  initial begin
    int f1;
    int r;
    int f2;
    logic [7:0] d;
    int i;
    vecs[0] = '{0, 8'hA5, 16'h034A, 40, "a5_none"};
    vecs[1] = '{1, 8'h07, 16'h060E, 44, "07_even"};
    vecs[2] = '{2, 8'h07, 16'h040E, 44, "07_odd"};
    vecs[3] = '{3, 8'h5A, 16'h06B4, 44, "5a_stop2"};
    vecs[4] = '{0, 8'hFF, 16'h03FE, 40, "ff_none"};
    for (int k = 0; k < 4; k++) begin
      data[k] = 8'h00;
      valid[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      check($sformatf("reset_state_%0d", k), {tx[k], ready[k], busy[k]} === 3'b110, longint'({tx[k], ready[k], busy[k]}), 6);
    rst = 1'b0;
    foreach (vecs[k]) begin
      int bad;
      run_frame(vecs[k].i, vecs[k].d, 1'b0, 8'h00, 1'b0);
      check({vecs[k].name, "_len"}, flen == vecs[k].len, flen, vecs[k].len);
      bad = -1;
      for (int c = 0; c < vecs[k].len; c++)
        if (bad < 0 && (c >= wave.size() || wave[c] !== vecs[k].bits[c / BD])) bad = c;
      check({vecs[k].name, "_wave_first_bad_cycle"}, bad < 0, bad, -1);
    end
    hist = {};
    rec = 1'b1;
    run_frame(3, 8'h00, 1'b1, 8'hFF, 1'b0);
    check_model(3, 8'h00, "b2b_first");
    run_frame(3, 8'hFF, 1'b0, 8'h00, 1'b0);
    check_model(3, 8'hFF, "b2b_second");
    rec = 1'b0;
    f1 = -1;
    r = -1;
    f2 = -1;
    foreach (hist[k]) begin
      if (f1 < 0 && hist[k] === 1'b0) f1 = k;
      else if (f1 >= 0 && r < 0 && hist[k] === 1'b1) r = k;
      else if (r >= 0 && f2 < 0 && hist[k] === 1'b0) f2 = k;
    end
    check("b2b_start_pitch", f1 >= 0 && f2 - f1 == 45, f2 - f1, 45);
    check("b2b_high_gap", r >= 0 && f2 - r == 9, f2 - r, 9);
    idle_watch(3, 60, "b2b_no_third_frame");
    run_frame(1, 8'h3C, 1'b0, 8'h00, 1'b1);
    check_model(1, 8'h3C, "abuse");
    idle_watch(1, 3 * 44, "abuse_no_extra_frame");
    data[0] = 8'h37;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_frame_data_bit3", tx[0] === 1'b0 && busy[0] === 1'b1, longint'(tx[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_frame", {tx[0], ready[0], busy[0]} === 3'b110, longint'({tx[0], ready[0], busy[0]}), 6);
    rst = 1'b0;
    run_frame(0, 8'hC3, 1'b0, 8'h00, 1'b0);
    check_model(0, 8'hC3, "after_reset");
    rst = 1'b1;
    valid[2] = 1'b1;
    data[2] = 8'h00;
    @(negedge clk);
    check("reset_beats_accept", {tx[2], ready[2], busy[2]} === 3'b110, longint'({tx[2], ready[2], busy[2]}), 6);
    rst = 1'b0;
    valid[2] = 1'b0;
    idle_watch(2, 20, "reset_accept_no_frame");
    repeat (20) begin
      i = $urandom_range(0, 3);
      d = 8'($urandom);
      run_frame(i, d, 1'b0, 8'h00, 1'($urandom));
      check_model(i, d, $sformatf("rnd_u%0d_%02h", i, d));
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Single-clock UART transmitter for the serial-port unit test: it takes bytes from the system side over a valid/ready handshake and serialises them onto a TX pin with an integrated baud-rate divider. It is the transmit end of the serial link. It runs entirely on the system clock and the synchronous reset generated by the clock block, so no clock-domain crossing is needed inside it.

## Interface
Parameters:
- BAUD_DIV, 217, system-clock cycles per bit (25 MHz / 115200); legal range 2..65535
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
- clk_i  input  1  system clock; every register in the block is clocked on its rising edge
- rst_i  input  1  reset, synchronous, active-high
- data_i  input  8  byte to send; sampled only on an accept edge
- valid_i  input  1  data_i is valid
- ready_o  output  1  block can accept a byte; registered
- tx_o  output  1  serial line, idle high; registered, so it is glitch-free
- busy_o  output  1  a frame is in progress; registered

## Operation
- Accept: a rising edge where valid_i=1 and ready_o=1. On that edge:
  - data_i is latched into the shift register.
  - Parity is computed from the latched byte: even = XOR of the bits, odd = its inverse.
  - ready_o goes to 0, busy_o goes to 1, the state moves to START, and the bit counter loads BAUD_DIV-1.
- States:
  - IDLE: tx_o=1, ready_o=1.
  - START: tx_o=0.
  - DATA: 8 bits, LSB first. The shift register shifts right at each bit boundary.
  - PARITY: only when PARITY≠0.
  - STOP: tx_o=1 for STOP_BITS bit periods.
  - Return to IDLE after STOP.
- Bit timing: the baud counter decrements each cycle. When it reaches 0 it reloads BAUD_DIV-1 and the FSM advances one bit.
- Counter widths:
  - Baud counter: $clog2(BAUD_DIV) bits.
  - Data-bit counter: 3 bits; it leaves DATA when it reaches 7 and the bit period ends.
  - Stop counter: 1 bit.
- Frame length: N = 1 + 8 + (PARITY≠0) + STOP_BITS bits, i.e. N*BAUD_DIV cycles.
- valid_i while ready_o=0: ignored. data_i must be held by the producer until it is accepted.
- Reset:
  - tx_o=1, ready_o=1, busy_o=0, state IDLE, counters 0.
  - These values hold for every cycle rst_i is high and take effect on the first edge.
  - Reset has priority over an accept on the same edge: the byte is dropped.
- Reset mid-frame: the frame is aborted and tx_o is 1 after that edge. The receiver may see a framing error; this is accepted behaviour.

## Timing
- Accept edge T:
  - tx_o=0 from T+1 for BAUD_DIV cycles.
  - Data bit k occupies [T+1+(k+1)*BAUD_DIV, T+1+(k+2)*BAUD_DIV).
- Final stop bit ends at edge T+N*BAUD_DIV. On that edge the state returns to IDLE, ready_o=1 and busy_o=0 (all registered).
- Back-to-back: with valid_i held high, the next accept is at edge T+N*BAUD_DIV+1.
  - Frame pitch is N*BAUD_DIV+1 cycles.
  - The line stays high for STOP_BITS*BAUD_DIV+1 cycles between frames.
- ready_o and busy_o are exact complements at all times.
- No combinational path from any input to any output.

## Test plan
- Single byte: BAUD_DIV=4, PARITY=0, STOP_BITS=1, send 0xA5 → ready_o low from T+1.
  - tx_o reads 0,1,0,1,0,0,1,0,1,1, each level 4 cycles.
  - ready_o is high again at T+40.
- Parity: BAUD_DIV=4, send 0x07.
  - PARITY=1 → parity bit 1.
  - PARITY=2 → parity bit 0.
  - Frame length 44 cycles in both cases.
- Back-to-back: STOP_BITS=2, valid_i held high with 0x00 then 0xFF.
  - Second start bit falls exactly 4*11+1=45 cycles after the first.
  - Line high for 9 cycles between frames.
  - No byte lost or duplicated.
- Handshake abuse: data_i changes and valid_i toggles while busy.
  - Transmitted byte equals the value latched at accept.
  - No extra frame is sent.
- Reset mid-frame: assert rst_i during data bit 3.
  - Next cycle: tx_o=1, ready_o=1, busy_o=0.
  - A fresh byte sent after reset is transmitted correctly.
- Reset with valid_i=1 on the same edge → no frame starts; tx_o stays 1.
